stepper_move_sched: RTL and testbench

//  Motion scheduler for the external A4988 stepper driver. It accepts move commands
//  (direction + step count) from two requesters, e.g. debounced s1 (CW) and s2 (CCW).
//  It arbitrates between them and sequences the dir/step pins with A4988-safe timing.

---
 rtl/stepper_move_sched.sv | 191 +++++++++++++++++++
 tb/tb_stepper_move_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/stepper_move_sched.sv
// Motion scheduler for an A4988 stepper driver: arbitrates two move requesters and
// sequences DIR/STEP with setup, pulse-width and period timing.
module stepper_move_sched #(
   parameter int STEPS_W         = 16,
   parameter int DIR_SETUP_CYC   = 25,
   parameter int STEP_HIGH_CYC   = 100,
   parameter int STEP_PERIOD_CYC = 50000
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               req0,
   input  logic               dir0,
   input  logic [STEPS_W-1:0] steps0,
   output logic               ack0,
   input  logic               req1,
   input  logic               dir1,
   input  logic [STEPS_W-1:0] steps1,
   output logic               ack1,
   input  logic               abort,
   output logic               dir,
   output logic               step,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic               owner,
   output logic [STEPS_W-1:0] steps_left
);

   localparam int CNT_MAX = (DIR_SETUP_CYC > STEP_PERIOD_CYC) ? DIR_SETUP_CYC : STEP_PERIOD_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(DIR_SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(STEP_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] LOW_LD   = CNT_W'(STEP_PERIOD_CYC - STEP_HIGH_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_HIGH  = 3'd2,
      S_LOW   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [STEPS_W-1:0] steps_left_q, steps_left_d;
   logic               dir_q, dir_d;
   logic               owner_q, owner_d;
   logic               rr_q, rr_d;
   logic               abort_pend_q, abort_pend_d;
   logic               ack0_q, ack0_d;
   logic               ack1_q, ack1_d;
   logic               aborted_q, aborted_d;
   logic               step_q, step_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pick1_s;
   logic [STEPS_W-1:0] steps_dec_s;

   // Next-state, counter reload and registered-output decode.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      steps_left_d = steps_left_q;
      dir_d        = dir_q;
      owner_d      = owner_q;
      rr_d         = rr_q;
      abort_pend_d = abort_pend_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      aborted_d    = 1'b0;
      pick1_s      = 1'b0;
      steps_dec_s  = (steps_left_q != {STEPS_W{1'b0}}) ? (steps_left_q - {{(STEPS_W-1){1'b0}}, 1'b1})
                                                       : steps_left_q;
      case (state_q)
         S_IDLE: begin
            abort_pend_d = 1'b0;
            // rr_q names the requester that wins when both ask at once.
            pick1_s      = req1 & (~req0 | rr_q);
            if (req0 | req1) begin
               ack0_d       = ~pick1_s;
               ack1_d       = pick1_s;
               owner_d      = pick1_s;
               rr_d         = ~pick1_s;
               dir_d        = pick1_s ? dir1 : dir0;
               steps_left_d = pick1_s ? steps1 : steps0;
               cnt_d        = SETUP_LD;
               state_d      = S_SETUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETUP: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_DONE;
            end else if (steps_left_q == {STEPS_W{1'b0}}) begin
               state_d = S_DONE;
            end else if (cnt_q == {CNT_W{1'b0}}) begin
               cnt_d   = HIGH_LD;
               state_d = S_HIGH;
            end else begin
               cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         S_HIGH: begin
            // An abort seen mid-pulse is remembered so the pulse still completes.
            abort_pend_d = abort_pend_q | abort;
            if (cnt_q == {CNT_W{1'b0}}) begin
               steps_left_d = steps_dec_s;
               if (abort_pend_q | abort) begin
                  aborted_d = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  cnt_d   = LOW_LD;
                  state_d = S_LOW;
               end
            end else begin
               cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         S_LOW: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_DONE;
            end else if (cnt_q == {CNT_W{1'b0}}) begin
               if (steps_left_q == {STEPS_W{1'b0}}) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d   = HIGH_LD;
                  state_d = S_HIGH;
               end
            end else begin
               cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      step_d = (state_d == S_HIGH);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers; reset clears STEP immediately.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= {CNT_W{1'b0}};
         steps_left_q <= {STEPS_W{1'b0}};
         dir_q        <= 1'b0;
         owner_q      <= 1'b0;
         rr_q         <= 1'b0;
         abort_pend_q <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         aborted_q    <= 1'b0;
         step_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         steps_left_q <= steps_left_d;
         dir_q        <= dir_d;
         owner_q      <= owner_d;
         rr_q         <= rr_d;
         abort_pend_q <= abort_pend_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         aborted_q    <= aborted_d;
         step_q       <= step_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign dir        = dir_q;
   assign step       = step_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign owner      = owner_q;
   assign steps_left = steps_left_q;

endmodule

// File: tb/tb_stepper_move_sched.sv
// Bench for stepper_move_sched: directed and random moves checked cycle by cycle
// against step timing computed arithmetically from the move parameters.
module tb_stepper_move_sched;
   localparam int SW = 16;
   localparam int S  = 3;
   localparam int H  = 2;
   localparam int P  = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0 = 1'b0, dir0 = 1'b0, req1 = 1'b0, dir1 = 1'b0, abort = 1'b0;
   logic [SW-1:0] steps0 = '0, steps1 = '0;
   logic          ack0, ack1, dir, step, busy, done, aborted, owner;
   logic [SW-1:0] steps_left;

   int   checks = 0;
   int   errors = 0;
   logic prio   = 1'b0;

   stepper_move_sched #(
      .STEPS_W(SW), .DIR_SETUP_CYC(S), .STEP_HIGH_CYC(H), .STEP_PERIOD_CYC(P)
   ) dut (
      .CLOCK_50(clk), .reset(rst),
      .req0(req0), .dir0(dir0), .steps0(steps0), .ack0(ack0),
      .req1(req1), .dir1(dir1), .steps1(steps1), .ack1(ack1),
      .abort(abort), .dir(dir), .step(step), .busy(busy), .done(done),
      .aborted(aborted), .owner(owner), .steps_left(steps_left)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Remaining steps r cycles after the ack: one is consumed at the end of each high phase.
   function automatic int exp_sl(input int n, input int r);
      int k, ph, v;
      if (n == 0 || r < S) return n;
      k  = (r - S) / P;
      ph = (r - S) % P;
      v  = n - k - ((ph >= H) ? 1 : 0);
      return (v < 0) ? 0 : v;
   endfunction

   function automatic int exp_step(input int n, input int r, input int e);
      if (r >= e || n == 0 || r < S) return 0;
      return (((r - S) % P) < H) ? 1 : 0;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; abort = 1'b0;
      prio = 1'b0;
      @(negedge clk);
      check("rst_step", 32'(step), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dir", 32'(dir), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_ack", 32'({ack0, ack1}), 32'd0);
      check("rst_steps_left", 32'(steps_left), 32'd0);
      rst = 1'b0;
   endtask

   // Run one move from an idle negedge; requests must already be set up by the caller.
   task automatic move(input int abort_at, input bit idle_abort, input int raise1_at);
      int   w, n, e_norm, e, k, ph, ra;
      logic win, d;
      bit   ab;
      win = (req0 && req1) ? prio : (req0 ? 1'b0 : 1'b1);
      n   = win ? int'(steps1) : int'(steps0);
      d   = win ? dir1 : dir0;
      abort = idle_abort;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!(ack0 || ack1) && w < 20);
      check("grant_latency", 32'(w), 32'd1);
      check("ack0", 32'(ack0), 32'(!win));
      check("ack1", 32'(ack1), 32'(win));
      check("owner", 32'(owner), 32'(win));
      check("dir_at_grant", 32'(dir), 32'(d));
      check("busy_at_grant", 32'(busy), 32'd1);
      check("step_at_grant", 32'(step), 32'd0);
      check("steps_left_at_grant", 32'(steps_left), 32'(n));
      prio = ~win;
      if (win) req1 = 1'b0; else req0 = 1'b0;
      e_norm = (n == 0) ? 1 : S + n * P;
      ab = (abort_at >= 0) && (abort_at < e_norm);
      ra = ab ? abort_at : -1;
      if (!ab) e = e_norm;
      else if (ra < S) e = ra + 1;
      else begin
         k  = (ra - S) / P;
         ph = (ra - S) % P;
         e  = (ph < H) ? (S + k * P + H) : (ra + 1);
      end
      abort = (ra == 0);
      for (int r = 1; r <= e + 1; r++) begin
         @(negedge clk);
         abort = (ra == r);
         if (r == raise1_at) req1 = 1'b1;
         if (r <= e) begin
            check("step", 32'(step), 32'(exp_step(n, r, e)));
            check("busy", 32'(busy), 32'd1);
            check("done", 32'(done), 32'(r == e));
            check("aborted", 32'(aborted), 32'((r == e) && ab));
            check("steps_left", 32'(steps_left), 32'(exp_sl(n, r)));
         end else begin
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_step", 32'(step), 32'd0);
            check("idle_done", 32'(done), 32'd0);
         end
         check("no_ack_while_busy", 32'({ack0, ack1}), 32'd0);
         check("dir_stable", 32'(dir), 32'(d));
      end
      abort = 1'b0;
   endtask

   initial begin
      int w;
      do_reset();

      // Basic three-step move.
      dir0 = 1'b1; steps0 = 16'd3; req0 = 1'b1;
      move(-1, 1'b0, -1);

      // Simultaneous requests after reset, then the loser, then another conflict.
      do_reset();
      dir0 = 1'b0; steps0 = 16'd2; dir1 = 1'b1; steps1 = 16'd1;
      req0 = 1'b1; req1 = 1'b1;
      move(-1, 1'b0, -1);
      move(-1, 1'b0, -1);
      steps0 = 16'd1; steps1 = 16'd1; req0 = 1'b1; req1 = 1'b1;
      move(-1, 1'b0, -1);
      move(-1, 1'b0, -1);

      // Zero-step move.
      dir1 = 1'b0; steps1 = 16'd0; req1 = 1'b1;
      move(-1, 1'b0, -1);

      // Abort at the first and second cycle of the second pulse.
      dir0 = 1'b1; steps0 = 16'd10; req0 = 1'b1;
      move(S + P, 1'b0, -1);
      steps0 = 16'd10; req0 = 1'b1;
      move(S + P + 1, 1'b0, -1);
      // Abort in setup and in low phase.
      steps0 = 16'd4; req0 = 1'b1;
      move(1, 1'b0, -1);
      steps0 = 16'd4; req0 = 1'b1;
      move(S + H + 1, 1'b0, -1);

      // Request raised while busy is served right after.
      dir0 = 1'b0; steps0 = 16'd2; dir1 = 1'b1; steps1 = 16'd1; req0 = 1'b1;
      move(-1, 1'b0, 2);
      move(-1, 1'b0, -1);

      // Abort while idle is ignored.
      steps0 = 16'd1; req0 = 1'b1;
      move(-1, 1'b1, -1);

      // Random moves.
      for (int it = 0; it < 30; it++) begin
         int sel, ab_at;
         if (!req0 && ($urandom_range(0, 1) == 1)) begin
            req0 = 1'b1; dir0 = 1'($urandom_range(0, 1)); steps0 = SW'($urandom_range(0, 5));
         end
         if (!req1 && ($urandom_range(0, 1) == 1)) begin
            req1 = 1'b1; dir1 = 1'($urandom_range(0, 1)); steps1 = SW'($urandom_range(0, 5));
         end
         if (!req0 && !req1) begin
            req0 = 1'b1; dir0 = 1'($urandom_range(0, 1)); steps0 = SW'($urandom_range(0, 5));
         end
         sel   = int'($urandom_range(0, 2));
         ab_at = (sel == 0) ? -1 : int'($urandom_range(0, 25));
         move(ab_at, 1'b0, -1);
      end
      if (req0 || req1) move(-1, 1'b0, -1);

      // Reset in the middle of a high phase.
      dir0 = 1'b1; steps0 = 16'd10; req0 = 1'b1;
      w = 0;
      do begin
         @(negedge clk);
         w++;
         if (ack0) req0 = 1'b0;
      end while (!step && w < 40);
      check("reached_high", 32'(step), 32'd1);
      req0 = 1'b0;
      rst = 1'b1;
      #1;
      check("async_rst_step", 32'(step), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      prio = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check("post_rst_step", 32'(step), 32'd0);
         check("post_rst_busy", 32'(busy), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
